// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronise and debounce four active-low keys into levels, pulses and a single-key press event
//
// Purpose: front-end for the KEY-driven games. Each raw key passes through a
// two-flop synchroniser and a per-key debounce counter. The block then produces
// clean levels, one-cycle edge pulses and a validated single-key press.
//
// Ports:
//   CLOCK_50    in   1  clock, all state updates on the rising edge
//   RESET       in   1  synchronous, active-high reset
//   KEY         in   4  raw buttons, asynchronous, active-low
//   KEY_STATE   out  4  debounced level, 1 = held
//   PRESS       out  4  one-cycle pulse when KEY_STATE[i] rises
//   RELEASE     out  4  one-cycle pulse when KEY_STATE[i] falls
//   PRESS_VALID out  1  one-cycle pulse for a press with no other key held
//   PRESS_IDX   out  2  index of the last valid press, held between events
//   MULTI       out  1  1 while two or more keys are held
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] KEY,
  output logic [3:0] KEY_STATE,
  output logic [3:0] PRESS,
  output logic [3:0] RELEASE,
  output logic       PRESS_VALID,
  output logic [1:0] PRESS_IDX,
  output logic       MULTI
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       p;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       state_next;
  logic [3:0]       flip;
  logic [3:0]       press_next;
  logic [3:0]       release_next;
  logic             valid_next;
  logic [1:0]       idx_next;
  logic             multi_next;

  // Synchronised keys converted to active-high.
  assign p = ~s2;

  always_comb begin
    state_next = KEY_STATE;
    flip       = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (p[i] != KEY_STATE[i]) begin
        if (cnt[i] < CNT_MAX) begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end else begin
          // Mismatch has persisted for DEBOUNCE_CYCLES evaluations: accept it.
          state_next[i] = p[i];
          flip[i]       = 1'b1;
        end
      end
    end

    press_next   = flip & state_next;
    release_next = flip & ~state_next;

    // A clean press is a lone rising key with nothing else held afterwards.
    valid_next = ($countones(press_next) == 1) && (state_next == press_next);

    idx_next = PRESS_IDX;
    if (valid_next) begin
      for (int i = 0; i < 4; i++) begin
        if (press_next[i]) begin
          idx_next = 2'(i);
        end
      end
    end

    // Derived from the next state so MULTI always agrees with KEY_STATE.
    multi_next = ($countones(state_next) > 1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1          <= 4'b1111;
      s2          <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      KEY_STATE   <= 4'b0000;
      PRESS       <= 4'b0000;
      RELEASE     <= 4'b0000;
      PRESS_VALID <= 1'b0;
      PRESS_IDX   <= 2'd0;
      MULTI       <= 1'b0;
    end else begin
      s1          <= KEY;
      s2          <= s1;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
      KEY_STATE   <= state_next;
      PRESS       <= press_next;
      RELEASE     <= release_next;
      PRESS_VALID <= valid_next;
      PRESS_IDX   <= idx_next;
      MULTI       <= multi_next;
    end
  end

endmodule
